// File: rtl/vga_scan_driver.sv
// ---------------------------------------------------------------------------
// vga_scan_driver
//
// Raster timing source and final pixel output stage for the display pipeline.
// The default parameters give 800x600 at 72 Hz from a 50 MHz pixel rate.
//
// The block provides:
//   - free-running horizontal and vertical scan counters, presented as X/Y
//   - a once-per-frame frameTick at the start of vertical blanking
//   - registered hsync/vsync pins (positive polarity)
//   - registered colour: widget colour, background, or black in blanking
//
// Ports:
//   clk                     in   system clock
//   reset                   in   asynchronous, active-low reset
//   pixEn                   in   pixel-rate enable (tie high at 50 MHz clk)
//   X, Y                    out  11-bit scan coordinates (raw counters)
//   frameTick               out  one-pixel pulse at (0, V_VIS), qualified by pixEn
//   widgetYes               in   widget claims pixel (X,Y)
//   redIn/greenIn/blueIn    in   4-bit widget colour
//   bgRed/bgGreen/bgBlue    in   4-bit background colour
//   hsync, vsync            out  registered sync pins
//   red/green/blue          out  registered 4-bit pixel colour
//
// Build option:
//   VGA_BORDER_EN  when defined, the outermost active pixels (first/last
//                  column and first/last line) are forced to white (FFF),
//                  overriding widget and background colour.
// ---------------------------------------------------------------------------
module vga_scan_driver #(
  parameter int H_VIS  = 800,
  parameter int H_FP   = 56,
  parameter int H_SYNC = 120,
  parameter int H_BP   = 64,
  parameter int V_VIS  = 600,
  parameter int V_FP   = 37,
  parameter int V_SYNC = 6,
  parameter int V_BP   = 23
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixEn,
  output logic [10:0] X,
  output logic [10:0] Y,
  output logic        frameTick,
  input  logic        widgetYes,
  input  logic [3:0]  redIn,
  input  logic [3:0]  greenIn,
  input  logic [3:0]  blueIn,
  input  logic [3:0]  bgRed,
  input  logic [3:0]  bgGreen,
  input  logic [3:0]  bgBlue,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue
);

  localparam logic [10:0] H_LAST     = 11'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_LAST     = 11'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] H_VIS_W    = 11'(H_VIS);
  localparam logic [10:0] V_VIS_W    = 11'(V_VIS);
  localparam logic [10:0] HS_FIRST   = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_LAST    = 11'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST   = 11'(V_VIS + V_FP);
  localparam logic [10:0] VS_LAST    = 11'(V_VIS + V_FP + V_SYNC - 1);
`ifdef VGA_BORDER_EN
  localparam logic [10:0] H_EDGE     = 11'(H_VIS - 1);
  localparam logic [10:0] V_EDGE     = 11'(V_VIS - 1);
`endif

  // Inclusive range test used by the sync decodes.
  function automatic logic in_range(input logic [10:0] val,
                                    input logic [10:0] lo,
                                    input logic [10:0] hi);
    in_range = (val >= lo) && (val <= hi);
  endfunction

  logic [10:0] h_count_r;
  logic [10:0] v_count_r;
  logic        active_s;
  logic        hsync_s;
  logic        vsync_s;
  logic [11:0] colour_s;
`ifdef VGA_BORDER_EN
  logic        border_s;
`endif

  // Scan counters: horizontal advances per pixel, vertical advances on line wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_count_r <= 11'd0;
      v_count_r <= 11'd0;
    end else if (pixEn) begin
      if (h_count_r == H_LAST) begin
        h_count_r <= 11'd0;
        if (v_count_r == V_LAST) begin
          v_count_r <= 11'd0;
        end else begin
          v_count_r <= v_count_r + 11'd1;
        end
      end else begin
        h_count_r <= h_count_r + 11'd1;
        v_count_r <= v_count_r;
      end
    end else begin
      h_count_r <= h_count_r;
      v_count_r <= v_count_r;
    end
  end

  assign X = h_count_r;
  assign Y = v_count_r;

  // Frame pulse decoded straight from the counters so widgets see it in the
  // same cycle the scan enters vertical blanking.
  assign frameTick = (h_count_r == 11'd0) && (v_count_r == V_VIS_W) && pixEn;

  // Visible-region and raw sync decode for the current coordinate.
  always_comb begin
    active_s = (h_count_r < H_VIS_W) && (v_count_r < V_VIS_W);
    hsync_s  = in_range(h_count_r, HS_FIRST, HS_LAST);
    vsync_s  = in_range(v_count_r, VS_FIRST, VS_LAST);
  end

`ifdef VGA_BORDER_EN
  // Outer ring of the visible area.
  always_comb begin
    border_s = (h_count_r == 11'd0) || (h_count_r == H_EDGE) ||
               (v_count_r == 11'd0) || (v_count_r == V_EDGE);
  end
`endif

  // Colour select: black in blanking, then (optional border), widget, background.
  always_comb begin
    colour_s = 12'h000;
    if (!active_s) begin
      colour_s = 12'h000;
    end
`ifdef VGA_BORDER_EN
    else if (border_s) begin
      colour_s = 12'hFFF;
    end
`endif
    else if (widgetYes) begin
      colour_s = {redIn, greenIn, blueIn};
    end else begin
      colour_s = {bgRed, bgGreen, bgBlue};
    end
  end

  // Output stage: sync and colour are registered together so they stay
  // aligned, one pixel behind X/Y.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync <= 1'b0;
      vsync <= 1'b0;
      red   <= 4'h0;
      green <= 4'h0;
      blue  <= 4'h0;
    end else if (pixEn) begin
      hsync <= hsync_s;
      vsync <= vsync_s;
      red   <= colour_s[11:8];
      green <= colour_s[7:4];
      blue  <= colour_s[3:0];
    end else begin
      hsync <= hsync;
      vsync <= vsync;
      red   <= red;
      green <= green;
      blue  <= blue;
    end
  end

endmodule

// File: tb/tb_vga_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_driver
//
// Self-checking bench for vga_scan_driver using a reduced raster so whole
// frames fit in a short run:
//   horizontal: 16 visible, 2 FP, 3 sync, 2 BP -> 23 per line, hsync X=18..20
//   vertical  :  8 visible, 2 FP, 2 sync, 2 BP -> 14 lines,    vsync Y=10..11
//   frame     : 322 pixel periods
// The bench acts as a widget claiming X=4..6 on Y=2 (colour ABC) over a
// background of 123. Border pixels expect FFF when VGA_BORDER_EN is defined.
// ---------------------------------------------------------------------------
module tb_vga_scan_driver;

  localparam int HT = 23;
  localparam int VT = 14;
  localparam int FRAME = HT * VT;
`ifdef VGA_BORDER_EN
  localparam logic [11:0] EDGE_RGB = 12'hFFF;
`else
  localparam logic [11:0] EDGE_RGB = 12'h123;
`endif

  logic        clk;
  logic        reset;
  logic        pixEn;
  logic [10:0] X, Y;
  logic        frameTick;
  logic        widgetYes;
  logic [3:0]  redIn, greenIn, blueIn;
  logic [3:0]  bgRed, bgGreen, bgBlue;
  logic        hsync, vsync;
  logic [3:0]  red, green, blue;

  int errors = 0;
  int checks = 0;
  int h_m = 0;
  int v_m = 0;

  vga_scan_driver #(
    .H_VIS(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(8),  .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut (
    .clk(clk), .reset(reset), .pixEn(pixEn),
    .X(X), .Y(Y), .frameTick(frameTick),
    .widgetYes(widgetYes),
    .redIn(redIn), .greenIn(greenIn), .blueIn(blueIn),
    .bgRed(bgRed), .bgGreen(bgGreen), .bgBlue(bgBlue),
    .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Widget stand-in: combinational claim from the scan coordinates.
  always_comb begin
    widgetYes = (X >= 11'd4) && (X <= 11'd6) && (Y == 11'd2);
  end

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic        tick;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clk with the given enable; the model advances when the DUT should.
  task automatic step(input logic pen);
    pixEn = pen;
    @(posedge clk);
    if (pen) begin
      if (h_m == HT - 1) begin
        h_m = 0;
        v_m = (v_m == VT - 1) ? 0 : v_m + 1;
      end else begin
        h_m = h_m + 1;
      end
    end
    #1;
  endtask

  function automatic vec_t mk(input int x, input int y, input logic t,
                              input logic hs, input logic vs, input logic [11:0] rgb);
    vec_t v;
    v.x = 11'(x); v.y = 11'(y); v.tick = t; v.hs = hs; v.vs = vs; v.rgb = rgb;
    return v;
  endfunction

  initial begin
    int n;
    int hs_cnt, vs_cnt, tk_cnt, rise1, rise2;
    logic hs_prev;
    logic [13:0] snap;
    int hold_err, xy_err;

    // Each entry: X/Y currently presented, expected frameTick for that
    // coordinate, and pins for the previous coordinate.
    vecs[0]  = mk(1, 0,  1'b0, 1'b0, 1'b0, EDGE_RGB); // pixel (0,0)
    vecs[1]  = mk(2, 0,  1'b0, 1'b0, 1'b0, EDGE_RGB); // (1,0) top line
    vecs[2]  = mk(2, 1,  1'b0, 1'b0, 1'b0, 12'h123);  // (1,1) background
    vecs[3]  = mk(5, 1,  1'b0, 1'b0, 1'b0, 12'h123);  // (4,1) no widget
    vecs[4]  = mk(4, 2,  1'b0, 1'b0, 1'b0, 12'h123);  // (3,2)
    vecs[5]  = mk(5, 2,  1'b0, 1'b0, 1'b0, 12'hABC);  // (4,2) widget start
    vecs[6]  = mk(7, 2,  1'b0, 1'b0, 1'b0, 12'hABC);  // (6,2) widget end
    vecs[7]  = mk(8, 2,  1'b0, 1'b0, 1'b0, 12'h123);  // (7,2)
    vecs[8]  = mk(16, 2, 1'b0, 1'b0, 1'b0, EDGE_RGB); // (15,2) last column
    vecs[9]  = mk(17, 2, 1'b0, 1'b0, 1'b0, 12'h000);  // (16,2) blanking
    vecs[10] = mk(18, 2, 1'b0, 1'b0, 1'b0, 12'h000);  // (17,2) before sync
    vecs[11] = mk(19, 2, 1'b0, 1'b1, 1'b0, 12'h000);  // (18,2) hsync first
    vecs[12] = mk(21, 2, 1'b0, 1'b1, 1'b0, 12'h000);  // (20,2) hsync last
    vecs[13] = mk(22, 2, 1'b0, 1'b0, 1'b0, 12'h000);  // (21,2)
    vecs[14] = mk(0, 3,  1'b0, 1'b0, 1'b0, 12'h000);  // (22,2) line end
    vecs[15] = mk(4, 7,  1'b0, 1'b0, 1'b0, EDGE_RGB); // (3,7) last line
    vecs[16] = mk(0, 8,  1'b1, 1'b0, 1'b0, 12'h000);  // frameTick point
    vecs[17] = mk(1, 8,  1'b0, 1'b0, 1'b0, 12'h000);  // (0,8) blank line
    vecs[18] = mk(0, 10, 1'b0, 1'b0, 1'b0, 12'h000);  // (22,9)
    vecs[19] = mk(1, 10, 1'b0, 1'b0, 1'b1, 12'h000);  // (0,10) vsync first
    vecs[20] = mk(0, 12, 1'b0, 1'b0, 1'b1, 12'h000);  // (22,11) vsync last
    vecs[21] = mk(1, 12, 1'b0, 1'b0, 1'b0, 12'h000);  // (0,12)
    vecs[22] = mk(0, 0,  1'b0, 1'b0, 1'b0, 12'h000);  // (22,13) frame wrap
    vecs[23] = mk(1, 0,  1'b0, 1'b0, 1'b0, EDGE_RGB); // (0,0) second frame

    reset = 1'b0;
    pixEn = 1'b0;
    redIn = 4'hA; greenIn = 4'hB; blueIn = 4'hC;
    bgRed = 4'h1; bgGreen = 4'h2; bgBlue = 4'h3;

    // Power-on reset state.
    step(1'b1);
    step(1'b1);
    h_m = 0; v_m = 0;
    chk("por_xy",  {X, Y}, 22'd0);
    chk("por_pins", {hsync, vsync, red, green, blue, frameTick}, 15'd0);

    // Run into the frame, then reset mid-line with non-zero colour on the pins.
    reset = 1'b1;
    n = 0;
    while (!(h_m == 10 && v_m == 1) && n < 100) begin step(1'b1); n++; end
    chk("pre_reset_xy", {X, Y}, {11'd10, 11'd1});
    chk("pre_reset_rgb", {red, green, blue}, 12'h123);
    reset = 1'b0;
    #1;
    chk("rst_xy", {X, Y}, 22'd0);
    chk("rst_pins", {hsync, vsync, red, green, blue, frameTick}, 15'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_hold_xy", {X, Y}, 22'd0);
    reset = 1'b1;
    h_m = 0; v_m = 0;
    chk("release_x0", {21'd0, X}, 32'd0);

    // Table-driven scan through one frame and into the next.
    for (int i = 0; i < 24; i++) begin
      n = 0;
      while (!(h_m == int'(vecs[i].x) && v_m == int'(vecs[i].y)) && n < 2 * FRAME) begin
        step(1'b1);
        n++;
      end
      if (n >= 2 * FRAME) begin
        chk($sformatf("vec%0d_reach", i), 32'd0, 32'd1);
      end else begin
        chk($sformatf("vec%0d_xy", i), {10'd0, X, Y}, {10'd0, vecs[i].x, vecs[i].y});
        chk($sformatf("vec%0d_tick", i), {31'd0, frameTick}, {31'd0, vecs[i].tick});
        chk($sformatf("vec%0d_sync", i), {30'd0, hsync, vsync}, {30'd0, vecs[i].hs, vecs[i].vs});
        chk($sformatf("vec%0d_rgb", i), {20'd0, red, green, blue}, {20'd0, vecs[i].rgb});
      end
    end

    // One full frame with pixEn held high: sync widths, line period, one tick.
    hs_cnt = 0; vs_cnt = 0; tk_cnt = 0; rise1 = -1; rise2 = -1;
    hs_prev = hsync;
    for (int c = 0; c < FRAME; c++) begin
      step(1'b1);
      if (hsync) hs_cnt++;
      if (vsync) vs_cnt++;
      if (frameTick) tk_cnt++;
      if (hsync && !hs_prev) begin
        if (rise1 < 0) rise1 = c;
        else if (rise2 < 0) rise2 = c;
      end
      hs_prev = hsync;
    end
    chk("hsync_cycles", hs_cnt, 3 * VT);
    chk("vsync_cycles", vs_cnt, 2 * HT);
    chk("tick_per_frame", tk_cnt, 1);
    chk("line_period", rise2 - rise1, HT);
    chk("frame_xy", {X, Y}, {11'd1, 11'd0});

    // pixEn toggling: counters advance every other clk, pins hold on idle clks,
    // and a frame takes twice as many clks with still only one tick.
    tk_cnt = 0; hold_err = 0; xy_err = 0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      logic pen;
      pen = (c % 2 == 0);
      pixEn = pen;
      #1;
      if (frameTick) tk_cnt++;
      snap = {hsync, vsync, red, green, blue};
      step(pen);
      if (!pen && ({hsync, vsync, red, green, blue} !== snap)) hold_err++;
      if (X !== 11'(h_m) || Y !== 11'(v_m)) xy_err++;
    end
    chk("toggle_tick", tk_cnt, 1);
    chk("toggle_hold", hold_err, 0);
    chk("toggle_xy", xy_err, 0);
    chk("toggle_frame_xy", {X, Y}, {11'd1, 11'd0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/vga_scan_driver.md
# vga_scan_driver

Raster timing source and pixel output stage for the 800x600 display pipeline. Generates the X/Y scan coordinates that every widget compares against, the once-per-frame `frameTick` that widgets use as their motion enable, and the VGA `hsync`/`vsync` pins. It also registers the final colour: widget colour where the widget claims the pixel, background elsewhere, and black during blanking. Sits between the widget layer and the DAC pins; timing is 800x600 at 72 Hz with a 50 MHz pixel rate.

## Interface
Parameters:
- `H_VIS`, 800, visible pixels per line
- `H_FP`, 56, horizontal front porch
- `H_SYNC`, 120, hsync width
- `H_BP`, 64, horizontal back porch (line total 1040)
- `V_VIS`, 600, visible lines
- `V_FP`, 37, vertical front porch
- `V_SYNC`, 6, vsync width
- `V_BP`, 23, vertical back porch (frame total 666)

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `pixEn`  in  1  pixel-rate enable; tie high at a 50 MHz `clk`
- `X`, `Y`  out  11 each  current scan coordinates (raw counters)
- `frameTick`  out  1  one-pixel pulse at start of vertical blanking
- `widgetYes`  in  1  widget claims pixel (X,Y); combinational from X/Y
- `redIn`, `greenIn`, `blueIn`  in  4 each  widget colour
- `bgRed`, `bgGreen`, `bgBlue`  in  4 each  background colour
- `hsync`, `vsync`  out  1 each  sync pins, positive polarity
- `red`, `green`, `blue`  out  4 each  registered pixel colour

## Operation
- `hCount` runs 0..1039 and `vCount` runs 0..665; both are driven directly as `X` and `Y`.
- On each `pixEn`, `hCount` increments. At 1039 it wraps to 0 and `vCount` increments; `vCount` wraps 665 -> 0 when `hCount` wraps.
- `active` = (`hCount` < 800) && (`vCount` < 600).
- Sync raw decode:
  - hsync: 856 <= `hCount` <= 975
  - vsync: 637 <= `vCount` <= 642
- `frameTick` is a combinational decode of the registered counters. It is 1 when (`hCount`==0 && `vCount`==600 && `pixEn`), so each frame gives exactly one pulse qualified by `pixEn`.
- Colour select:
  - !`active` -> 0
  - else `widgetYes` -> {redIn,greenIn,blueIn}
  - else {bgRed,bgGreen,bgBlue}
- Output stage: on `pixEn`, register `hsync`, `vsync` and `red`/`green`/`blue` from the current counters and colour select.
- When `pixEn` = 0, all registers hold.
- Reset (async assert, mid-frame included) forces `hCount`=`vCount`=0, `hsync`=`vsync`=0 and rgb=0 immediately. The first count occurs on the first `pixEn` after deassertion.

## Timing
- X/Y to pins latency is one `pixEn` cycle: colour and sync for coordinate (x,y) appear on the pins while X/Y show the next coordinate. Sync and colour stay mutually aligned.
- The widget path (`widgetYes`, colour inputs) must settle within one `clk` period of X/Y changing. It is sampled on the same edge that advances X/Y.
- Line period: 1040 `pixEn` cycles. Frame period: 692,640 `pixEn` cycles.
- `frameTick` falls at the start of blanking, giving widgets 66 lines of blanking in which to update position before `vCount` returns to 0.
- Reset values of all outputs:
  - `X`=0, `Y`=0
  - `hsync`=0, `vsync`=0
  - rgb=0
  - `frameTick`=0

## Configuration
- `VGA_BORDER_EN` defined: an active pixel with `hCount`∈{0,799} or `vCount`∈{0,599} outputs colour 4'hF/4'hF/4'hF. This overrides both widget and background colour. Latency is unchanged.
- Not defined: no border logic; the colour select is exactly as in Operation.

## Test plan
- Reset asserted mid-line (`hCount`=400): all outputs 0 immediately. After release with `pixEn`=1, X counts 0,1,2… from the first edge.
- `pixEn`=1 free-running, line timing: pin `hsync` rises on the cycle after X=856 is presented and stays high for exactly 120 cycles. The line period is 1040 cycles.
- Frame timing: pin `vsync` is high for 6×1040 = 6240 cycles. `frameTick` pulses exactly once per 692,640 cycles, while X=0 and Y=600.
- Colour path: background 4'h1/4'h2/4'h3, `widgetYes`=1 only for X in 100..109 on Y=50, widget colour 4'hA/4'hB/4'hC. Pins show ABC for exactly 10 cycles, one cycle delayed, and 123 elsewhere on that line. The pins show 0 during X>=800.
- `pixEn` toggling 1/0 each cycle: X advances every other `clk`, and the frame length is 1,385,280 `clk` cycles. Outputs hold while `pixEn`=0.
- With `VGA_BORDER_EN`: the pixel at (0,0), (799,300) and (400,599) is FFF regardless of `widgetYes`. The pixel at (1,1) is the background colour.
